// File: rtl/comfort_ctrl.sv
// comfort_ctrl - room comfort controller (heater / fan / fault supervision)
//
// Accepts temperature and humidity readings from a sensor reader on each
// rising edge of done_i. It keeps a heat/idle/cool hysteresis state
// machine, drives a proportional fan PWM while cooling, and raises an
// alarm when no plausible reading has arrived for TIMEOUT cycles.
//
// Optional build macro:
//   AVG_FILTER_EN - control and temp_o use a 4-sample moving average of the
//                   accepted temperatures instead of the raw latest value.
//
// Ports:
//   clk_i      in   system clock, all logic on the rising edge
//   rst_i      in   synchronous active-high reset
//   done_i     in   sensor reader done flag (rising edge = new reading)
//   temp_i     in   [7:0] temperature in degC
//   hum_i      in   [7:0] humidity
//   heater_o   out  heater enable (state == HEAT)
//   fan_pwm_o  out  fan PWM drive
//   state_o    out  [1:0] 00 IDLE, 01 HEAT, 10 COOL, 11 FAULT
//   alarm_o    out  high while in FAULT
//   temp_o     out  [7:0] last accepted (filtered) temperature
//   hum_o      out  [7:0] last accepted humidity
module comfort_ctrl #(
    parameter int T_HEAT_ON   = 18,
    parameter int T_COOL_ON   = 28,
    parameter int HYST        = 2,
    parameter int T_MAX_VALID = 60,
    parameter int DUTY_STEP   = 32,
    parameter int TIMEOUT     = 300000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       done_i,
    input  logic [7:0] temp_i,
    input  logic [7:0] hum_i,
    output logic       heater_o,
    output logic       fan_pwm_o,
    output logic [1:0] state_o,
    output logic       alarm_o,
    output logic [7:0] temp_o,
    output logic [7:0] hum_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [7:0] HEAT_ON   = 8'(T_HEAT_ON);
    localparam logic [7:0] HEAT_OFF  = 8'(T_HEAT_ON + HYST);
    localparam logic [7:0] COOL_ON   = 8'(T_COOL_ON);
    localparam logic [7:0] COOL_OFF  = 8'(T_COOL_ON - HYST);
    localparam logic [7:0] MAX_VALID = 8'(T_MAX_VALID);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HEAT  = 2'b01,
        COOL  = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic          done_q;
    logic          eval_q;
    logic          accept;
    logic          valid;
    logic          fault_trig;
    logic [TW-1:0] to_cnt;
    logic [7:0]    temp_q;
    logic [7:0]    hum_q;
    logic [7:0]    temp_new;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty;
    logic [7:0]    duty_calc;
    logic [15:0]   excess;
    logic [15:0]   duty_wide;
    logic          heater_q;
    logic          alarm_q;

    // A held-high done_i produces a single accept because only the 0->1
    // transition against the registered copy counts.
    assign accept = done_i & ~done_q;
    assign valid  = accept && (temp_i <= MAX_VALID);

    // A valid accept in the same cycle the counter expires rescues the
    // controller from FAULT; an implausible one does not.
    assign fault_trig = (to_cnt == TO_LAST) && !valid;

`ifdef AVG_FILTER_EN
    logic [7:0] hist0, hist1, hist2;
    logic       primed;
    logic [9:0] avg_sum;

    // The new sample plus the three previous ones form the 4-sample window.
    // Until the first valid sample arrives the history is meaningless, so
    // that sample is passed straight through and copied into every slot.
    assign avg_sum  = {2'b00, temp_i} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
    assign temp_new = primed ? 8'(avg_sum >> 2) : temp_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist0  <= 8'd0;
            hist1  <= 8'd0;
            hist2  <= 8'd0;
            primed <= 1'b0;
        end else if (valid) begin
            hist0  <= temp_i;
            hist1  <= primed ? hist0 : temp_i;
            hist2  <= primed ? hist1 : temp_i;
            primed <= 1'b1;
        end
    end
`else
    assign temp_new = temp_i;
`endif

    // Sample capture. eval_q delays the state decision by one edge so it
    // works from the freshly registered temperature.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            eval_q <= 1'b0;
            temp_q <= 8'd0;
            hum_q  <= 8'd0;
        end else begin
            done_q <= done_i;
            eval_q <= valid;
            if (valid) begin
                temp_q <= temp_new;
                hum_q  <= hum_i;
            end
        end
    end

    // Cycles since the last valid sample; parks at TO_LAST so FAULT is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (valid) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Next-state logic. FAULT re-enters the normal regime using the same
    // thresholds as IDLE; HEAT and COOL always pass through IDLE.
    always_comb begin
        state_nxt = state;
        if (fault_trig) begin
            state_nxt = FAULT;
        end else if (eval_q) begin
            case (state)
                IDLE, FAULT: begin
                    if (temp_q <= HEAT_ON)      state_nxt = HEAT;
                    else if (temp_q >= COOL_ON) state_nxt = COOL;
                    else                        state_nxt = IDLE;
                end
                HEAT: if (temp_q >= HEAT_OFF) state_nxt = IDLE;
                COOL: if (temp_q <= COOL_OFF) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register with heater/alarm flops decoded from the next state so
    // they change on the same edge as state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            heater_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            heater_q <= (state_nxt == HEAT);
            alarm_q  <= (state_nxt == FAULT);
        end
    end

    // Proportional duty: one step per degree at or above T_COOL_ON. Below
    // that (still cooling inside the hysteresis band) the fan is off.
    always_comb begin
        excess    = 16'(temp_q) + 16'd1 - 16'(T_COOL_ON);
        duty_wide = excess * 16'(DUTY_STEP);
        if (temp_q < COOL_ON)           duty_calc = 8'd0;
        else if (duty_wide > 16'd255)   duty_calc = 8'hFF;
        else                            duty_calc = duty_wide[7:0];
    end

    // Duty only changes at the end of a PWM period so every period on the
    // fan pin is complete.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_cnt <= 8'd0;
            duty    <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) begin
                duty <= (state == COOL) ? duty_calc : 8'd0;
            end
        end
    end

    assign fan_pwm_o = (pwm_cnt < duty);
    assign heater_o  = heater_q;
    assign alarm_o   = alarm_q;
    assign state_o   = state;
    assign temp_o    = temp_q;
    assign hum_o     = hum_q;

endmodule

// File: tb/tb_comfort_ctrl.sv
// tb_comfort_ctrl - directed self-checking bench for comfort_ctrl
// (TIMEOUT overridden to 1000; build with AVG_FILTER_EN for the filter run).
module tb_comfort_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       done_i;
    logic [7:0] temp_i;
    logic [7:0] hum_i;
    logic       heater_o;
    logic       fan_pwm_o;
    logic [1:0] state_o;
    logic       alarm_o;
    logic [7:0] temp_o;
    logic [7:0] hum_o;

    int checks    = 0;
    int errors    = 0;
    int since_acc = 0;
    int highs;
    int waited;

    comfort_ctrl #(.TIMEOUT(1000)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .done_i    (done_i),
        .temp_i    (temp_i),
        .hum_i     (hum_i),
        .heater_o  (heater_o),
        .fan_pwm_o (fan_pwm_o),
        .state_o   (state_o),
        .alarm_o   (alarm_o),
        .temp_o    (temp_o),
        .hum_o     (hum_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock, then settle 1 time unit past the edge before looking.
    task automatic tick();
        @(posedge clk_i);
        #1;
        since_acc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One done pulse; afterwards temp_o and state_o both reflect the sample.
    task automatic applyStimulus(input logic [7:0] t, input logic [7:0] h, input bit is_valid);
        temp_i = t;
        hum_i  = h;
        done_i = 1'b1;
        tick();
        if (is_valid) since_acc = 0;
        done_i = 1'b0;
        tick();
    endtask

    // 256 consecutive cycles = one full PWM period in any phase.
    task automatic countFan(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (fan_pwm_o) n++;
            tick();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_state"},  32'(state_o),   32'd0);
        checkOutput({tag, "_heater"}, 32'(heater_o),  32'd0);
        checkOutput({tag, "_fan"},    32'(fan_pwm_o), 32'd0);
        checkOutput({tag, "_alarm"},  32'(alarm_o),   32'd0);
        checkOutput({tag, "_temp"},   32'(temp_o),    32'd0);
        checkOutput({tag, "_hum"},    32'(hum_o),     32'd0);
    endtask

    initial begin
        rst_i  = 1'b1;
        done_i = 1'b0;
        temp_i = 8'd0;
        hum_i  = 8'd0;
        ticks(2);
        checkAllZero("reset");
        rst_i = 1'b0;
        tick();

`ifdef AVG_FILTER_EN
        applyStimulus(8'd20, 8'd40, 1'b1);
        checkOutput("avg1_temp", 32'(temp_o), 32'd20);
        checkOutput("avg1_state", 32'(state_o), 32'd0);
        applyStimulus(8'd20, 8'd41, 1'b1);
        checkOutput("avg2_temp", 32'(temp_o), 32'd20);
        applyStimulus(8'd20, 8'd42, 1'b1);
        checkOutput("avg3_temp", 32'(temp_o), 32'd20);
        applyStimulus(8'd32, 8'd43, 1'b1);
        checkOutput("avg4_temp", 32'(temp_o), 32'd23);
        checkOutput("avg4_hum", 32'(hum_o), 32'd43);
        checkOutput("avg4_state", 32'(state_o), 32'd0);
`else
        // First reading, comfortable band
        applyStimulus(8'd25, 8'd50, 1'b1);
        checkOutput("first_temp", 32'(temp_o), 32'd25);
        checkOutput("first_hum", 32'(hum_o), 32'd50);
        checkOutput("first_state", 32'(state_o), 32'd0);
        checkOutput("first_heater", 32'(heater_o), 32'd0);
        checkOutput("first_fan", 32'(fan_pwm_o), 32'd0);

        // 18 -> HEAT, with the one-edge gap between temp_o and state_o
        temp_i = 8'd18;
        hum_i  = 8'd51;
        done_i = 1'b1;
        tick();
        since_acc = 0;
        checkOutput("lat_temp", 32'(temp_o), 32'd18);
        checkOutput("lat_state_old", 32'(state_o), 32'd0);
        done_i = 1'b0;
        tick();
        checkOutput("heat18_state", 32'(state_o), 32'd1);
        checkOutput("heat18_heater", 32'(heater_o), 32'd1);

        applyStimulus(8'd19, 8'd51, 1'b1);
        checkOutput("heat19_state", 32'(state_o), 32'd1);
        checkOutput("heat19_heater", 32'(heater_o), 32'd1);
        applyStimulus(8'd20, 8'd51, 1'b1);
        checkOutput("heat20_state", 32'(state_o), 32'd0);
        checkOutput("heat20_heater", 32'(heater_o), 32'd0);

        // Cooling: (30-28+1)*32 = 96, then 40 saturates at 255
        applyStimulus(8'd30, 8'd52, 1'b1);
        checkOutput("cool30_state", 32'(state_o), 32'd2);
        ticks(256);
        countFan(highs);
        checkOutput("cool30_duty", 32'(highs), 32'd96);

        applyStimulus(8'd40, 8'd53, 1'b1);
        checkOutput("cool40_state", 32'(state_o), 32'd2);
        ticks(256);
        countFan(highs);
        checkOutput("cool40_duty", 32'(highs), 32'd255);

        applyStimulus(8'd26, 8'd54, 1'b1);
        checkOutput("cool26_state", 32'(state_o), 32'd0);
        ticks(256);
        countFan(highs);
        checkOutput("cool26_duty", 32'(highs), 32'd0);

        // Timeout: FAULT exactly 1000 edges after the last valid accept
        while (since_acc < 999) tick();
        checkOutput("to_edge999_state", 32'(state_o), 32'd0);
        checkOutput("to_edge999_alarm", 32'(alarm_o), 32'd0);
        tick();
        checkOutput("to_fault_state", 32'(state_o), 32'd3);
        checkOutput("to_fault_alarm", 32'(alarm_o), 32'd1);

        applyStimulus(8'd15, 8'd40, 1'b1);
        checkOutput("fault15_state", 32'(state_o), 32'd1);
        checkOutput("fault15_alarm", 32'(alarm_o), 32'd0);
        checkOutput("fault15_heater", 32'(heater_o), 32'd1);
        checkOutput("fault15_temp", 32'(temp_o), 32'd15);

        // Implausible reading: nothing changes, counter keeps running
        applyStimulus(8'd70, 8'd77, 1'b0);
        checkOutput("bad70_temp", 32'(temp_o), 32'd15);
        checkOutput("bad70_hum", 32'(hum_o), 32'd40);
        checkOutput("bad70_state", 32'(state_o), 32'd1);
        while (since_acc < 999) tick();
        checkOutput("bad70_pre_to_state", 32'(state_o), 32'd1);
        tick();
        checkOutput("bad70_to_state", 32'(state_o), 32'd3);

        applyStimulus(8'd20, 8'd45, 1'b1);
        checkOutput("recover_state", 32'(state_o), 32'd0);
        checkOutput("recover_alarm", 32'(alarm_o), 32'd0);

        // Held done_i: only the first reading is taken
        temp_i = 8'd25;
        hum_i  = 8'd60;
        done_i = 1'b1;
        tick();
        since_acc = 0;
        temp_i = 8'd35;
        hum_i  = 8'd61;
        ticks(499);
        done_i = 1'b0;
        tick();
        checkOutput("held_temp", 32'(temp_o), 32'd25);
        checkOutput("held_hum", 32'(hum_o), 32'd60);
        checkOutput("held_state", 32'(state_o), 32'd0);

        // Reset while cooling with the fan pin high
        applyStimulus(8'd30, 8'd62, 1'b1);
        checkOutput("prerst_state", 32'(state_o), 32'd2);
        ticks(260);
        waited = 0;
        while (!fan_pwm_o && waited < 300) begin
            tick();
            waited++;
        end
        checkOutput("prerst_fan_high", 32'(fan_pwm_o), 32'd1);
        rst_i = 1'b1;
        tick();
        checkAllZero("midrst");
        rst_i = 1'b0;
        tick();
        checkOutput("postrst_state", 32'(state_o), 32'd0);
        checkOutput("postrst_fan", 32'(fan_pwm_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comfort_ctrl.md
COMFORT_CTRL -- requirements
Module: comfort_ctrl

Interface
REQ-001 Parameter T_HEAT_ON, default 18, heater engage threshold in degC (integer).
REQ-002 Parameter T_COOL_ON, default 28, fan engage threshold in degC.
REQ-003 Parameter HYST, default 2, hysteresis band in degC.
REQ-004 Parameter T_MAX_VALID, default 60, highest plausible temperature in degC.
REQ-005 Parameter DUTY_STEP, default 32, fan duty increment per degC above T_COOL_ON.
REQ-006 Parameter TIMEOUT, default 300000000, clock cycles without a valid sample before fault.
REQ-007 Port clk_i, input, 1 bit: single system clock; all logic on its rising edge.
REQ-008 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-009 Port done_i, input, 1 bit: sensor reader done flag; a rising edge marks a new reading.
REQ-010 Port temp_i, input, 8 bits: integer temperature from the sensor reader.
REQ-011 Port hum_i, input, 8 bits: integer humidity from the sensor reader.
REQ-012 Port heater_o, output, 1 bit: heater enable.
REQ-013 Port fan_pwm_o, output, 1 bit: fan PWM drive.
REQ-014 Port state_o, output, 2 bits: 00 IDLE, 01 HEAT, 10 COOL, 11 FAULT.
REQ-015 Port alarm_o, output, 1 bit: high while in FAULT.
REQ-016 Port temp_o / hum_o, output, 8 bits each: last accepted (filtered) temperature and last accepted humidity.

Function
REQ-017 done_i SHALL be registered once; an accept event occurs in the cycle where done_i=1 and its registered copy=0; a held-high done_i yields exactly one accept.
REQ-018 On accept, a sample with temp_i > T_MAX_VALID SHALL be rejected: no register, counter or state update.
REQ-019 On a valid accept, temp_o/hum_o SHALL update on that clock edge, the timeout counter SHALL clear, and state_o SHALL update on the next edge (2-edge latency from done_i sampled high).
REQ-020 IDLE: temp <= T_HEAT_ON -> HEAT; temp >= T_COOL_ON -> COOL; else stay.
REQ-021 HEAT: temp >= T_HEAT_ON+HYST -> IDLE; COOL: temp <= T_COOL_ON-HYST -> IDLE; no direct HEAT<->COOL transition.
REQ-022 Any state: timeout counter reaching TIMEOUT-1 SHALL enter FAULT next edge; counter saturates there.
REQ-023 FAULT: next valid accept SHALL evaluate per IDLE rules (REQ-020) and leave FAULT; timeout wins over an accept landing in the same cycle only if the accept is invalid.
REQ-024 heater_o = (state==HEAT); alarm_o = (state==FAULT); both registered.
REQ-025 8-bit PWM counter SHALL free-run 0..255 and wrap; fan_pwm_o = (counter < duty).
REQ-026 duty = 0 outside COOL; in COOL duty = min(255, (temp - T_COOL_ON + 1) * DUTY_STEP), computed at 16 bits then saturated.
REQ-027 Active duty SHALL load only when counter==255 so no truncated PWM period occurs; leaving COOL forces duty=0 at the same point.

Reset
REQ-028 rst_i high at a clock edge SHALL set state IDLE, heater_o=0, fan_pwm_o=0, alarm_o=0, temp_o=0, hum_o=0, duty=0, PWM and timeout counters=0, done register=0.
REQ-029 Reset asserted mid-PWM-period or mid-FAULT SHALL take effect on that edge with no residual output.

Configuration
REQ-030 Macro AVG_FILTER_EN defined: temperature used by REQ-020..026 and shown on temp_o SHALL be the 4-sample moving average (sum of last 4 valid samples >> 2, truncating), history preloaded with the first valid sample after reset; macro undefined: raw latched temp_i is used, no history registers.

Verification (TIMEOUT overridden to 1000, filter off unless stated)
REQ-031 Reset, then temp=25 hum=50 done pulse -> temp_o=25, hum_o=50, state IDLE, heater_o=0, fan_pwm_o=0.
REQ-032 Sequence temp 18,19,20 -> HEAT after 18, still HEAT at 19, IDLE at 20; heater_o tracks.
REQ-033 temp=30 -> COOL, duty 96 from next counter wrap (fan high 96 of 256 cycles); temp=40 -> duty 255 saturated; temp=26 -> IDLE, fan 0.
REQ-034 No done for 1000 cycles -> FAULT, alarm_o=1; temp=15 accept -> HEAT, alarm_o=0; temp=70 accept -> ignored, outputs unchanged.
REQ-035 done_i held high 500 cycles -> exactly one accept; reset asserted in COOL mid-period -> all outputs 0 next edge.
REQ-036 AVG_FILTER_EN: samples 20,20,20,32 -> temp_o 20,20,20,23; state stays IDLE.
